vga_compositor: RTL and testbench

Parametrised successor to the dual-mode VGA display stage. Takes palette indices from the external text and graphics video memories and composites them into one 24-bit pixel stream, using a writable palette RAM and a graphics window with colour-key transparency. It also draws a blinking hardware text cursor. It sits between the video memories and the VGA DAC pins, and is driven by the same pixel counters (`xloc`, `yloc`).

---
 rtl/vga_compositor.sv | 207 ++++++++++++++++++++
 tb/tb_vga_compositor.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_compositor.sv
// Composites text and graphics palette indices into a registered 24-bit VGA pixel,
// with shadowed window/mode registers, colour-key transparency and a blinking text cursor.
module vga_compositor #(
    parameter int PAL_BITS     = 4,
    parameter int COLOR_W      = 8,
    parameter int X_W          = 10,
    parameter int Y_W          = 9,
    parameter int CELL_W_LOG2  = 3,
    parameter int CELL_H_LOG2  = 4,
    parameter int MEM_LAT      = 1,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [X_W-1:0]         xloc,
    input  logic [Y_W-1:0]         yloc,
    input  logic [PAL_BITS-1:0]    text_pal_i,
    input  logic [PAL_BITS-1:0]    graph_pal_i,
    output logic [X_W-1:0]         graph_x_o,
    output logic [Y_W-1:0]         graph_y_o,
    input  logic                   reg_we_i,
    input  logic [2:0]             reg_addr_i,
    input  logic [15:0]            reg_wdata_i,
    input  logic                   pal_we_i,
    input  logic [PAL_BITS-1:0]    pal_addr_i,
    input  logic [3*COLOR_W-1:0]   pal_data_i,
    output logic                   frame_start_o,
    output logic [COLOR_W-1:0]     VGA_R,
    output logic [COLOR_W-1:0]     VGA_G,
    output logic [COLOR_W-1:0]     VGA_B
);
    localparam int PAL_N = 1 << PAL_BITS;
    localparam int RGB_W = 3 * COLOR_W;
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int REPS  = (COLOR_W + PAL_BITS - 1) / PAL_BITS;

    typedef struct packed {
        logic valid;
        logic full;
        logic win;
        logic hit;
    } flags_t;

    // Grey ramp: the index repeated MSB-first until the channel is filled.
    function automatic logic [COLOR_W-1:0] grey(input int unsigned idx);
        logic [REPS*PAL_BITS-1:0] rep;
        rep = {REPS{PAL_BITS'(idx)}};
        return rep[REPS*PAL_BITS-1 -: COLOR_W];
    endfunction

    logic [1:0]          mode_s_q, mode_q;
    logic [X_W-1:0]      win_x_s_q, win_x_q, win_w_s_q, win_w_q;
    logic [Y_W-1:0]      win_y_s_q, win_y_q, win_h_s_q, win_h_q;
    logic                key_en_q, cur_en_q;
    logic [PAL_BITS-1:0] key_q, cur_idx_q;
    logic [7:0]          cur_row_q, cur_col_q;
    logic                prev_origin_q;
    logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic [RGB_W-1:0]    pal_q [PAL_N];
    flags_t              dly_q [MEM_LAT];
    flags_t              flags_d, aligned;
    logic [RGB_W-1:0]    rgb_q, rgb_d;
    logic [PAL_BITS-1:0] sel_idx_d;

    logic                at_origin, in_win, keyed, cell_hit, bottom_rows;
    logic [X_W:0]        x_end;
    logic [Y_W:0]        y_end;
    logic [X_W-1:0]      cell_x;
    logic [Y_W-1:0]      cell_y;

    assign at_origin     = (xloc == '0) && (yloc == '0);
    assign frame_start_o = at_origin && !prev_origin_q;

    assign x_end  = {1'b0, win_x_q} + {1'b0, win_w_q};
    assign y_end  = {1'b0, win_y_q} + {1'b0, win_h_q};
    assign in_win = (xloc >= win_x_q) && ({1'b0, xloc} < x_end) &&
                    (yloc >= win_y_q) && ({1'b0, yloc} < y_end);

    assign cell_x      = xloc >> CELL_W_LOG2;
    assign cell_y      = yloc >> CELL_H_LOG2;
    assign bottom_rows = yloc[CELL_H_LOG2-1:0] >= CELL_H_LOG2'((1 << CELL_H_LOG2) - 2);
    assign cell_hit    = (32'(cell_x) == 32'(cur_col_q)) && (32'(cell_y) == 32'(cur_row_q));

    always_comb begin
        graph_x_o = '0;
        graph_y_o = '0;
        if (mode_q == 2'd1) begin
            graph_x_o = xloc;
            graph_y_o = yloc;
        end else if (mode_q == 2'd2 && in_win) begin
            graph_x_o = xloc - win_x_q;
            graph_y_o = yloc - win_y_q;
        end
    end

    always_comb begin
        flags_d.valid = 1'b1;
        flags_d.full  = (mode_q == 2'd1);
        flags_d.win   = (mode_q == 2'd2) && in_win;
        flags_d.hit   = cur_en_q && blink_phase_q && cell_hit && bottom_rows;
    end

    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_start_o) begin
            if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Flags were captured MEM_LAT cycles ago, so they line up with the memory indices now.
    assign aligned = dly_q[MEM_LAT-1];
    assign keyed   = key_en_q && (graph_pal_i == key_q);

    always_comb begin
        sel_idx_d = text_pal_i;
        if (aligned.full || (aligned.win && !keyed))
            sel_idx_d = graph_pal_i;
        else if (aligned.hit)
            sel_idx_d = cur_idx_q;
        rgb_d = aligned.valid ? pal_q[sel_idx_d] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_s_q  <= '0;  mode_q  <= '0;
            win_x_s_q <= '0;  win_x_q <= '0;
            win_y_s_q <= '0;  win_y_q <= '0;
            win_w_s_q <= '0;  win_w_q <= '0;
            win_h_s_q <= '0;  win_h_q <= '0;
            key_en_q  <= 1'b0;
            key_q     <= '0;
            cur_row_q <= '0;
            cur_col_q <= '0;
            cur_en_q  <= 1'b0;
            cur_idx_q <= '1;
        end else begin
            // Active copies take the pre-write staging value even if a write lands this cycle.
            if (frame_start_o) begin
                mode_q  <= mode_s_q;
                win_x_q <= win_x_s_q;
                win_y_q <= win_y_s_q;
                win_w_q <= win_w_s_q;
                win_h_q <= win_h_s_q;
            end
            if (reg_we_i) begin
                case (reg_addr_i)
                    3'd0: mode_s_q  <= reg_wdata_i[1:0];
                    3'd1: win_x_s_q <= reg_wdata_i[X_W-1:0];
                    3'd2: win_y_s_q <= reg_wdata_i[Y_W-1:0];
                    3'd3: win_w_s_q <= reg_wdata_i[X_W-1:0];
                    3'd4: win_h_s_q <= reg_wdata_i[Y_W-1:0];
                    3'd5: begin
                        key_en_q <= reg_wdata_i[PAL_BITS];
                        key_q    <= reg_wdata_i[PAL_BITS-1:0];
                    end
                    3'd6: begin
                        cur_row_q <= reg_wdata_i[15:8];
                        cur_col_q <= reg_wdata_i[7:0];
                    end
                    default: begin
                        cur_en_q  <= reg_wdata_i[PAL_BITS];
                        cur_idx_q <= reg_wdata_i[PAL_BITS-1:0];
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_origin_q <= 1'b0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            rgb_q         <= '0;
            for (int unsigned i = 0; i < MEM_LAT; i++)
                dly_q[i] <= '0;
        end else begin
            prev_origin_q <= at_origin;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            rgb_q         <= rgb_d;
            dly_q[0]      <= flags_d;
            for (int unsigned i = 1; i < MEM_LAT; i++)
                dly_q[i] <= dly_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PAL_N; i++)
                pal_q[i] <= {3{grey(i)}};
        end else if (pal_we_i) begin
            pal_q[pal_addr_i] <= pal_data_i;
        end
    end

    assign VGA_R = rgb_q[RGB_W-1 -: COLOR_W];
    assign VGA_G = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign VGA_B = rgb_q[COLOR_W-1:0];
endmodule

// File: tb/tb_vga_compositor.sv
// Directed bench for vga_compositor: a scoreboard queue holds expected pixels pushed
// when a coordinate is driven and popped when the registered pixel appears.
module tb_vga_compositor;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  xloc;
    logic [8:0]  yloc;
    logic [3:0]  text_pal_i, graph_pal_i;
    logic [9:0]  graph_x_o;
    logic [8:0]  graph_y_o;
    logic        reg_we_i;
    logic [2:0]  reg_addr_i;
    logic [15:0] reg_wdata_i;
    logic        pal_we_i;
    logic [3:0]  pal_addr_i;
    logic [23:0] pal_data_i;
    logic        frame_start_o;
    logic [7:0]  VGA_R, VGA_G, VGA_B;

    int total = 0;
    int bad = 0;
    int frames_seen = 0;
    int pulses;
    logic [23:0] pal_m [16];

    typedef struct {
        string       tag;
        logic [23:0] rgb;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    vga_compositor #(
        .PAL_BITS(4), .COLOR_W(8), .X_W(10), .Y_W(9), .CELL_W_LOG2(3),
        .CELL_H_LOG2(4), .MEM_LAT(1), .BLINK_FRAMES(30)
    ) dut (
        .clk(clk), .rst_n(rst_n), .xloc(xloc), .yloc(yloc),
        .text_pal_i(text_pal_i), .graph_pal_i(graph_pal_i),
        .graph_x_o(graph_x_o), .graph_y_o(graph_y_o),
        .reg_we_i(reg_we_i), .reg_addr_i(reg_addr_i), .reg_wdata_i(reg_wdata_i),
        .pal_we_i(pal_we_i), .pal_addr_i(pal_addr_i), .pal_data_i(pal_data_i),
        .frame_start_o(frame_start_o), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pal_reset_model();
        for (int i = 0; i < 16; i++) begin
            logic [7:0] g;
            g = 8'(i * 17);
            pal_m[i] = {g, g, g};
        end
    endtask

    task automatic pix(input int x, input int y, input int t, input int g,
                       input int eidx, input string tag);
        xloc = 10'(x);
        yloc = 9'(y);
        sb.push_back('{tag, pal_m[eidx]});
        tick();
        text_pal_i  = 4'(t);
        graph_pal_i = 4'(g);
        tick();
        e = sb.pop_front();
        chk(e.tag, {VGA_R, VGA_G, VGA_B}, e.rgb);
    endtask

    task automatic gcoord(input int x, input int y, input int ex, input int ey, input string tag);
        xloc = 10'(x);
        yloc = 9'(y);
        #1;
        chk({tag, "_gx"}, 24'(graph_x_o), 24'(ex));
        chk({tag, "_gy"}, 24'(graph_y_o), 24'(ey));
    endtask

    task automatic wreg(input int a, input int d);
        reg_we_i    = 1'b1;
        reg_addr_i  = 3'(a);
        reg_wdata_i = 16'(d);
        tick();
        reg_we_i = 1'b0;
    endtask

    task automatic frame(input bit do_wr, input int a, input int d);
        xloc = 10'd1;
        yloc = 9'd0;
        tick();
        xloc = 10'd0;
        yloc = 9'd0;
        if (do_wr) begin
            reg_we_i    = 1'b1;
            reg_addr_i  = 3'(a);
            reg_wdata_i = 16'(d);
        end
        #1;
        chk("frame_pulse", 24'(frame_start_o), 24'd1);
        tick();
        reg_we_i = 1'b0;
        xloc = 10'd1;
        yloc = 9'd1;
        frames_seen++;
    endtask

    initial begin
        rst_n = 1'b0;
        xloc = 10'd5; yloc = 9'd5;
        text_pal_i = 4'd5; graph_pal_i = 4'd0;
        reg_we_i = 1'b0; reg_addr_i = '0; reg_wdata_i = '0;
        pal_we_i = 1'b0; pal_addr_i = '0; pal_data_i = '0;
        pal_reset_model();

        tick();
        tick();
        chk("rst_rgb", {VGA_R, VGA_G, VGA_B}, 24'h0);
        chk("rst_fs", 24'(frame_start_o), 24'h0);
        rst_n = 1'b1;
        tick();
        chk("rst_black", {VGA_R, VGA_G, VGA_B}, 24'h0);
        tick();
        chk("rst_pal5", {VGA_R, VGA_G, VGA_B}, 24'h555555);

        pix(20, 20, 4, 0, 4, "pal_grey4");
        pix(20, 20, 15, 0, 15, "pal_grey15");

        pal_we_i = 1'b1; pal_addr_i = 4'd3; pal_data_i = 24'hFF0000;
        tick();
        pal_we_i = 1'b0;
        pal_m[3] = 24'hFF0000;
        pix(20, 20, 3, 0, 3, "pal_wr3");
        pix(20, 20, 4, 0, 4, "pal_keep4");

        // Read of entry 6 in its own write cycle returns the old value.
        xloc = 10'd30; yloc = 9'd30;
        sb.push_back('{"pal_rdw_old", pal_m[6]});
        tick();
        text_pal_i = 4'd6;
        pal_we_i = 1'b1; pal_addr_i = 4'd6; pal_data_i = 24'h00ABCD;
        tick();
        pal_we_i = 1'b0;
        e = sb.pop_front();
        chk(e.tag, {VGA_R, VGA_G, VGA_B}, e.rgb);
        pal_m[6] = 24'h00ABCD;
        pix(30, 30, 6, 0, 6, "pal_rdw_new");

        wreg(0, 2);
        wreg(1, 100);
        wreg(2, 50);
        wreg(3, 64);
        wreg(4, 32);
        gcoord(110, 55, 0, 0, "shadow");
        pix(110, 55, 1, 9, 1, "shadow_text");
        frame(0, 0, 0);
        gcoord(100, 50, 0, 0, "win_org");
        pix(100, 50, 1, 9, 9, "win_org_pix");
        gcoord(110, 55, 10, 5, "win_in");
        pix(110, 55, 1, 9, 9, "win_in_pix");
        gcoord(164, 50, 0, 0, "win_xend");
        pix(164, 50, 1, 9, 1, "win_xend_pix");
        gcoord(99, 50, 0, 0, "win_xlo");
        pix(99, 50, 1, 9, 1, "win_xlo_pix");
        pix(163, 81, 1, 9, 9, "win_corner_pix");
        pix(163, 82, 1, 9, 1, "win_yend_pix");

        wreg(5, 16'h0017);
        pix(110, 55, 2, 7, 2, "key_hit");
        pix(110, 55, 2, 6, 6, "key_miss");

        wreg(0, 1);
        frame(0, 0, 0);
        gcoord(5, 5, 5, 5, "full");
        pix(5, 5, 2, 8, 8, "full_pix");
        frame(1, 0, 0);
        pix(5, 5, 2, 8, 8, "wr_at_fs_old");
        frame(0, 0, 0);
        pix(5, 5, 2, 8, 2, "wr_at_fs_new");

        wreg(6, 16'h020A);
        wreg(7, 16'h001F);
        for (int f = 0; f < 64; f++) begin
            int ph;
            frame(0, 0, 0);
            ph = (frames_seen / 30) % 2;
            pix(80, 46, 1, 0, (ph == 1) ? 15 : 1, "cursor_bottom");
            pix(80, 45, 1, 0, 1, "cursor_above");
        end

        xloc = 10'd1; yloc = 9'd0;
        tick();
        xloc = 10'd0; yloc = 9'd0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            #2;
            if (frame_start_o) pulses++;
            tick();
        end
        chk("hold_origin_pulses", 24'(pulses), 24'd1);

        pix(40, 40, 5, 0, 5, "pre_reset");
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rgb", {VGA_R, VGA_G, VGA_B}, 24'h0);
        chk("async_rst_fs", 24'(frame_start_o), 24'h0);
        tick();
        rst_n = 1'b1;
        pal_reset_model();
        tick();
        pix(40, 40, 3, 0, 3, "post_reset_pal");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
